// File: rtl/tlp_xcvr_pkg.sv
// Shared F2C DMA ring geometry, pointer/address types and writer FSM states.
// Every size here is a power of two, so ring pointers wrap by plain truncation.
package tlp_xcvr_pkg;

    localparam int F2C_CHUNKSIZE    = 256;
    localparam int F2C_TLPSIZE      = 128;
    localparam int F2C_NUMCHUNKS    = 4;
    localparam int F2C_WRPTR_OFFSET = 0;

    typedef logic [$clog2(F2C_NUMCHUNKS)-1:0] F2CChunkPtr;
    typedef logic [60:0]                      QwAddr;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_PREQ,
        ST_PDATA
    } f2c_state_e;

endpackage

// File: rtl/f2c_dma_writer.sv
// Packs the application QW stream into ring chunks written as TLP-sized requests,
// then posts the advanced write pointer to the host metrics buffer.
module f2c_dma_writer
    import tlp_xcvr_pkg::*;
#(
    parameter int CHUNKSIZE = F2C_CHUNKSIZE,
    parameter int TLPSIZE   = F2C_TLPSIZE,
    parameter int NUMCHUNKS = F2C_NUMCHUNKS
) (
    input  logic                        clk_in,
    input  logic                        rstn,
    input  logic                        dmaEn_in,
    input  logic                        dmaReset_in,
    input  QwAddr                       f2cBase_in,
    input  QwAddr                       mtrBase_in,
    input  F2CChunkPtr                  rdPtr_in,
    input  logic [63:0]                 srcData_in,
    input  logic                        srcValid_in,
    output logic                        srcReady_out,
    output QwAddr                       reqAddr_out,
    output logic [$clog2(TLPSIZE/8):0]  reqLen_out,
    output logic                        reqValid_out,
    input  logic                        reqReady_in,
    output logic [63:0]                 datData_out,
    output logic                        datValid_out,
    input  logic                        datReady_in,
    output F2CChunkPtr                  wrPtr_out
);

    localparam int QWS_PER_TLP    = TLPSIZE / 8;
    localparam int TLPS_PER_CHUNK = CHUNKSIZE / TLPSIZE;
    localparam int QW_W           = (QWS_PER_TLP > 1) ? $clog2(QWS_PER_TLP) : 1;
    localparam int TLP_W          = (TLPS_PER_CHUNK > 1) ? $clog2(TLPS_PER_CHUNK) : 1;
    localparam int LEN_W          = $clog2(TLPSIZE / 8) + 1;

    f2c_state_e       state_q,   state_d;
    F2CChunkPtr       wr_ptr_q,  wr_ptr_d;
    logic [TLP_W-1:0] tlp_idx_q, tlp_idx_d;
    logic [QW_W-1:0]  qw_idx_q,  qw_idx_d;

    F2CChunkPtr wr_ptr_inc;
    logic       full;
    logic       beat;

    assign wr_ptr_inc = F2CChunkPtr'((32'(wr_ptr_q) + 1) % NUMCHUNKS);
    assign full       = (wr_ptr_inc == rdPtr_in);
    assign beat       = srcValid_in && datReady_in;
    assign wrPtr_out  = wr_ptr_q;

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            tlp_idx_q <= '0;
            qw_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            tlp_idx_q <= tlp_idx_d;
            qw_idx_q  <= qw_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tlp_idx_d    = tlp_idx_q;
        qw_idx_d     = qw_idx_q;
        srcReady_out = 1'b0;
        reqValid_out = 1'b0;
        reqAddr_out  = '0;
        reqLen_out   = '0;
        datData_out  = '0;
        datValid_out = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (dmaEn_in && !full) begin
                    state_d   = ST_REQ;
                    tlp_idx_d = '0;
                end
            end
            ST_REQ: begin
                reqValid_out = 1'b1;
                reqAddr_out  = f2cBase_in
                             + QwAddr'(wr_ptr_q)  * QwAddr'(CHUNKSIZE / 8)
                             + QwAddr'(tlp_idx_q) * QwAddr'(QWS_PER_TLP);
                reqLen_out   = LEN_W'(QWS_PER_TLP);
                if (reqReady_in) begin
                    state_d  = ST_DATA;
                    qw_idx_d = '0;
                end
            end
            ST_DATA: begin
                datData_out  = srcData_in;
                datValid_out = srcValid_in;
                srcReady_out = datReady_in;
                if (beat) begin
                    qw_idx_d = qw_idx_q + QW_W'(1);
                    if (qw_idx_q == QW_W'(QWS_PER_TLP - 1)) begin
                        // A disable only takes effect between TLPs; a partial chunk is dropped unposted.
                        if (tlp_idx_q == TLP_W'(TLPS_PER_CHUNK - 1)) begin
                            state_d = ST_PREQ;
                        end else begin
                            tlp_idx_d = tlp_idx_q + TLP_W'(1);
                            state_d   = dmaEn_in ? ST_REQ : ST_IDLE;
                        end
                    end
                end
            end
            ST_PREQ: begin
                reqValid_out = 1'b1;
                reqAddr_out  = mtrBase_in + QwAddr'(F2C_WRPTR_OFFSET);
                reqLen_out   = LEN_W'(1);
                if (reqReady_in) begin
                    state_d = ST_PDATA;
                end
            end
            ST_PDATA: begin
                datData_out  = 64'(wr_ptr_inc);
                datValid_out = 1'b1;
                if (datReady_in) begin
                    wr_ptr_d = wr_ptr_inc;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (dmaReset_in) begin
            state_d   = ST_IDLE;
            wr_ptr_d  = '0;
            tlp_idx_d = '0;
            qw_idx_d  = '0;
        end
    end

endmodule

// File: tb/tb_f2c_dma_writer.sv
// Directed bench for f2c_dma_writer: single chunk, ring-full/wrap, backpressure,
// mid-chunk disable, dmaReset during DATA and async reset during the pointer post.
module tb_f2c_dma_writer;
    import tlp_xcvr_pkg::*;

    logic                               clk_in = 1'b0;
    logic                               rstn;
    logic                               dmaEn_in;
    logic                               dmaReset_in;
    QwAddr                              f2cBase_in;
    QwAddr                              mtrBase_in;
    F2CChunkPtr                         rdPtr_in;
    logic [63:0]                        srcData_in;
    logic                               srcValid_in;
    logic                               srcReady_out;
    QwAddr                              reqAddr_out;
    logic [$clog2(F2C_TLPSIZE/8):0]     reqLen_out;
    logic                               reqValid_out;
    logic                               reqReady_in;
    logic [63:0]                        datData_out;
    logic                               datValid_out;
    logic                               datReady_in;
    F2CChunkPtr                         wrPtr_out;

    f2c_dma_writer dut (
        .clk_in       (clk_in),
        .rstn         (rstn),
        .dmaEn_in     (dmaEn_in),
        .dmaReset_in  (dmaReset_in),
        .f2cBase_in   (f2cBase_in),
        .mtrBase_in   (mtrBase_in),
        .rdPtr_in     (rdPtr_in),
        .srcData_in   (srcData_in),
        .srcValid_in  (srcValid_in),
        .srcReady_out (srcReady_out),
        .reqAddr_out  (reqAddr_out),
        .reqLen_out   (reqLen_out),
        .reqValid_out (reqValid_out),
        .reqReady_in  (reqReady_in),
        .datData_out  (datData_out),
        .datValid_out (datValid_out),
        .datReady_in  (datReady_in),
        .wrPtr_out    (wrPtr_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic       dma_en    = 1'b0;
    logic       dma_rst   = 1'b0;
    F2CChunkPtr rd_ptr    = '0;
    logic       rand_mode = 1'b0;

    int          src_idx = 0;
    int          pay_idx = 0;
    int          pay_cnt = 0;
    int          pay_err = 0;
    int          viol    = 0;
    logic        src_hold = 1'b0;
    logic        hold_req = 1'b0;
    logic        hold_dat = 1'b0;
    QwAddr       held_addr;
    logic [4:0]  held_len;
    logic [63:0] held_data;

    QwAddr       req_addr_q[$];
    int          req_len_q[$];
    logic [63:0] post_q[$];
    QwAddr       exp_addr_q[$];
    int          exp_len_q[$];
    logic [63:0] exp_post_q[$];

    function automatic logic [63:0] seq64(input int i);
        return {32'hF2C0_0000 | 32'(i), ~32'(i)};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, then sample what the next rising edge will see.
    task automatic apply_stimulus();
        @(negedge clk_in);
        dmaEn_in    = dma_en;
        dmaReset_in = dma_rst;
        rdPtr_in    = rd_ptr;
        if (!src_hold)
            srcValid_in = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        srcData_in  = seq64(src_idx);
        reqReady_in = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        datReady_in = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (hold_req && !(reqValid_out && reqAddr_out == held_addr && reqLen_out == held_len))
            viol++;
        if (hold_dat && !(datValid_out && datData_out == held_data))
            viol++;
        if (reqValid_out && reqReady_in) begin
            req_addr_q.push_back(reqAddr_out);
            req_len_q.push_back(int'(reqLen_out));
        end
        if (datValid_out && datReady_in) begin
            if (srcReady_out) begin
                if (datData_out !== seq64(pay_idx))
                    pay_err++;
                pay_idx++;
                pay_cnt++;
            end else begin
                post_q.push_back(datData_out);
            end
        end
        if (srcValid_in && srcReady_out)
            src_idx++;
        src_hold  = srcValid_in && !srcReady_out;
        hold_req  = reqValid_out && !reqReady_in && !dmaReset_in;
        held_addr = reqAddr_out;
        held_len  = reqLen_out;
        hold_dat  = datValid_out && !datReady_in && !dmaReset_in;
        held_data = datData_out;
    endtask

    task automatic clear_section();
        req_addr_q.delete();
        req_len_q.delete();
        post_q.delete();
        exp_addr_q.delete();
        exp_len_q.delete();
        exp_post_q.delete();
        pay_cnt = 0;
    endtask

    task automatic expect_req(input QwAddr addr, input int len);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(len);
    endtask

    task automatic verify_section(input string tag, input int exp_beats, input F2CChunkPtr exp_wrptr);
        check_output({tag, "_nreq"}, 64'(req_addr_q.size()), 64'(exp_addr_q.size()));
        foreach (exp_addr_q[i]) begin
            check_output($sformatf("%s_req%0d_addr", tag, i),
                         (i < req_addr_q.size()) ? 64'(req_addr_q[i]) : {64{1'bx}}, 64'(exp_addr_q[i]));
            check_output($sformatf("%s_req%0d_len", tag, i),
                         (i < req_len_q.size()) ? 64'(req_len_q[i]) : {64{1'bx}}, 64'(exp_len_q[i]));
        end
        check_output({tag, "_npost"}, 64'(post_q.size()), 64'(exp_post_q.size()));
        foreach (exp_post_q[i])
            check_output($sformatf("%s_post%0d", tag, i),
                         (i < post_q.size()) ? post_q[i] : {64{1'bx}}, exp_post_q[i]);
        check_output({tag, "_beats"}, 64'(pay_cnt), 64'(exp_beats));
        check_output({tag, "_payload_err"}, 64'(pay_err), 64'd0);
        check_output({tag, "_wrptr"}, 64'(wrPtr_out), 64'(exp_wrptr));
    endtask

    task automatic expect_three_chunks();
        expect_req(61'h00, 16); expect_req(61'h10, 16); expect_req(61'h100, 1);
        expect_req(61'h20, 16); expect_req(61'h30, 16); expect_req(61'h100, 1);
        expect_req(61'h40, 16); expect_req(61'h50, 16); expect_req(61'h100, 1);
        exp_post_q.push_back(64'd1);
        exp_post_q.push_back(64'd2);
        exp_post_q.push_back(64'd3);
    endtask

    initial begin
        int hits;
        rstn        = 1'b0;
        dmaEn_in    = 1'b0;
        dmaReset_in = 1'b0;
        f2cBase_in  = 61'h0;
        mtrBase_in  = 61'h100;
        rdPtr_in    = '0;
        srcData_in  = '0;
        srcValid_in = 1'b0;
        reqReady_in = 1'b0;
        datReady_in = 1'b0;

        #12;
        check_output("rst_srcReady", 64'(srcReady_out), 64'd0);
        check_output("rst_reqValid", 64'(reqValid_out), 64'd0);
        check_output("rst_datValid", 64'(datValid_out), 64'd0);
        check_output("rst_reqAddr",  64'(reqAddr_out),  64'd0);
        check_output("rst_reqLen",   64'(reqLen_out),   64'd0);
        check_output("rst_datData",  datData_out,       64'd0);
        check_output("rst_wrPtr",    64'(wrPtr_out),    64'd0);
        @(negedge clk_in);
        rstn = 1'b1;

        // Single chunk; rdPtr 2 makes the ring full once wrPtr reaches 1.
        dma_en = 1'b1;
        rd_ptr = 2'd2;
        clear_section();
        repeat (60) apply_stimulus();
        expect_req(61'h00, 16); expect_req(61'h10, 16); expect_req(61'h100, 1);
        exp_post_q.push_back(64'd1);
        verify_section("single", 32, 2'd1);
        check_output("single_idle_srcReady", 64'(srcReady_out), 64'd0);

        rd_ptr  = 2'd0;
        dma_rst = 1'b1;
        apply_stimulus();
        dma_rst = 1'b0;
        apply_stimulus();
        check_output("dmarst_idle_wrPtr", 64'(wrPtr_out), 64'd0);

        // Ring full with rdPtr 0: three chunks, then stall.
        clear_section();
        repeat (150) apply_stimulus();
        expect_three_chunks();
        verify_section("ring", 96, 2'd3);
        check_output("ring_full_srcReady", 64'(srcReady_out), 64'd0);
        check_output("ring_full_reqValid", 64'(reqValid_out), 64'd0);

        rd_ptr = 2'd1;
        clear_section();
        repeat (60) apply_stimulus();
        expect_req(61'h60, 16); expect_req(61'h70, 16); expect_req(61'h100, 1);
        exp_post_q.push_back(64'd0);
        verify_section("wrap", 32, 2'd0);

        // Random backpressure on every handshake.
        rd_ptr    = 2'd0;
        rand_mode = 1'b1;
        viol      = 0;
        clear_section();
        repeat (1500) apply_stimulus();
        expect_three_chunks();
        verify_section("bp", 96, 2'd3);
        check_output("bp_valid_stability", 64'(viol), 64'd0);
        rand_mode = 1'b0;
        apply_stimulus();

        // Disable during the first TLP of a chunk.
        dma_rst = 1'b1;
        apply_stimulus();
        dma_rst = 1'b0;
        clear_section();
        repeat (5) apply_stimulus();
        dma_en = 1'b0;
        repeat (40) apply_stimulus();
        expect_req(61'h00, 16);
        verify_section("disable", 16, 2'd0);
        check_output("disable_idle_reqValid", 64'(reqValid_out), 64'd0);

        dma_en = 1'b1;
        rd_ptr = 2'd2;
        clear_section();
        repeat (60) apply_stimulus();
        expect_req(61'h00, 16); expect_req(61'h10, 16); expect_req(61'h100, 1);
        exp_post_q.push_back(64'd1);
        verify_section("reenable", 32, 2'd1);

        // dmaReset while streaming.
        rd_ptr = 2'd0;
        repeat (4) apply_stimulus();
        check_output("pre_dmarst_datValid", 64'(datValid_out), 64'd1);
        dma_rst = 1'b1;
        apply_stimulus();
        dma_rst = 1'b0;
        apply_stimulus();
        check_output("dmarst_reqValid", 64'(reqValid_out), 64'd0);
        check_output("dmarst_datValid", 64'(datValid_out), 64'd0);
        check_output("dmarst_srcReady", 64'(srcReady_out), 64'd0);
        check_output("dmarst_wrPtr",    64'(wrPtr_out),    64'd0);

        // Async reset while the second chunk's pointer post request is pending.
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            apply_stimulus();
            if (reqValid_out && reqAddr_out == 61'h100)
                hits++;
            if (hits == 2)
                break;
        end
        check_output("preq_reached", 64'(hits), 64'd2);
        check_output("preq_wrPtr_before", 64'(wrPtr_out), 64'd1);
        rstn = 1'b0;
        #1;
        check_output("arst_reqValid", 64'(reqValid_out), 64'd0);
        check_output("arst_reqAddr",  64'(reqAddr_out),  64'd0);
        check_output("arst_reqLen",   64'(reqLen_out),   64'd0);
        check_output("arst_datValid", 64'(datValid_out), 64'd0);
        check_output("arst_datData",  datData_out,       64'd0);
        check_output("arst_srcReady", 64'(srcReady_out), 64'd0);
        check_output("arst_wrPtr",    64'(wrPtr_out),    64'd0);

        #20;
        rstn = 1'b1;
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
